// File: rtl/axi_up_bridge.sv
// AXI4-Lite slave that bridges single transactions onto the UP_WR/UP_RD
// register-access interfaces, with an ack timeout that answers SLVERR.
module axi_up_bridge #(
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_ADDR_WIDTH+1:0]   s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_ADDR_WIDTH+1:0]   s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_ADDR_WIDTH-1:0]   up_wr_addr,
  output logic [C_DATA_WIDTH/8-1:0] up_wr_be,
  output logic                      up_wr_req,
  output logic [C_DATA_WIDTH-1:0]   up_wr_din,
  input  logic                      up_wr_ack,
  output logic [C_ADDR_WIDTH-1:0]   up_rd_addr,
  output logic                      up_rd_req,
  input  logic [C_DATA_WIDTH-1:0]   up_rd_dout,
  input  logic                      up_rd_ack
);

  localparam int CW = $clog2(C_TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(C_TIMEOUT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [C_DATA_WIDTH-1:0] DEAD_WORD = {(C_DATA_WIDTH/32){32'hDEADDEAD}};

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_rd;
  logic          idle, wr_pend, rd_pend, pick_wr, wr_go, rd_go;
  logic          unused_addr_lsbs;

  // Byte-lane bits of the AXI addresses carry no meaning on the word-addressed UP side.
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies are gated by rst_n so they read 0 while reset is held, even with valids pending.
  assign idle    = (state == IDLE) && rst_n;
  assign wr_pend = s_axi_awvalid && s_axi_wvalid;
  assign rd_pend = s_axi_arvalid;
  assign pick_wr = wr_pend && (!rd_pend || last_rd);
  assign wr_go   = idle && pick_wr;
  assign rd_go   = idle && rd_pend && !pick_wr;

  assign s_axi_awready = wr_go;
  assign s_axi_wready  = wr_go;
  assign s_axi_arready = rd_go;

  // Transaction FSM: capture at handshake, pulse req, wait for ack or timeout, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_rd      <= 1'b1;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_bvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      up_wr_addr   <= '0;
      up_wr_be     <= '0;
      up_wr_din    <= '0;
      up_wr_req    <= 1'b0;
      up_rd_addr   <= '0;
      up_rd_req    <= 1'b0;
    end else begin
      up_wr_req <= 1'b0;
      up_rd_req <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_go) begin
            up_wr_addr <= s_axi_awaddr[C_ADDR_WIDTH+1:2];
            up_wr_be   <= s_axi_wstrb;
            up_wr_din  <= s_axi_wdata;
            up_wr_req  <= 1'b1;
            last_rd    <= 1'b0;
            state      <= WR_REQ;
          end else if (rd_go) begin
            up_rd_addr <= s_axi_araddr[C_ADDR_WIDTH+1:2];
            up_rd_req  <= 1'b1;
            last_rd    <= 1'b1;
            state      <= RD_REQ;
          end
        end
        WR_REQ: begin
          cnt   <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (up_wr_ack) begin
            s_axi_bresp  <= RESP_OKAY;
            s_axi_bvalid <= 1'b1;
            state        <= WR_RESP;
          end else if (cnt == TMAX) begin
            s_axi_bresp  <= RESP_SLVERR;
            s_axi_bvalid <= 1'b1;
            state        <= WR_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        RD_REQ: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (up_rd_ack) begin
            s_axi_rdata  <= up_rd_dout;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b1;
            state        <= RD_RESP;
          end else if (cnt == TMAX) begin
            s_axi_rdata  <= DEAD_WORD;
            s_axi_rresp  <= RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
            state        <= RD_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_up_bridge.md
# axi_up_bridge

AXI4-Lite slave that acts as the initiator on the UP_WR/UP_RD register-access interfaces. It turns each AXI4-Lite write or read into one UP request, waits for the responder's ack, and returns the AXI response. It sits between the processor interconnect and any UP responder, such as the up_bram block or the register banks. Only one transaction is outstanding at a time. A missing ack is bounded by a timeout that completes the transaction with an error.

## Interface
- C_ADDR_WIDTH, 10, UP word-address width; the AXI byte-address width is C_ADDR_WIDTH+2.
- C_DATA_WIDTH, 32, data width; only 32 is supported.
- C_TIMEOUT, 64, maximum number of cycles to wait for an ack after a UP request; must be ≥ 2.
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous and active-low.
- s_axi_awaddr  in  C_ADDR_WIDTH+2  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  C_ADDR_WIDTH+2  read byte address.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- up_wr_addr, up_wr_be, up_wr_req, up_wr_din  out  C_ADDR_WIDTH, 4, 1, 32  UP write request.
- up_wr_ack  in  1  UP write acknowledge.
- up_rd_addr, up_rd_req  out  C_ADDR_WIDTH, 1  UP read request.
- up_rd_dout  in  32  UP read data, valid while up_rd_ack is high.
- up_rd_ack  in  1  UP read acknowledge.

## Operation
- **FSM states:** IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP. Reset state is IDLE.
- **Accepting a write:** only in IDLE, and only when awvalid and wvalid are both high. s_axi_awready and s_axi_wready are combinational and rise together in that cycle. Neither is ever accepted alone.
- **Accepting a read:** only in IDLE, when arvalid is high. s_axi_arready is combinational and high in that cycle.
- **Arbitration:** if a write and a read are both pending in IDLE, a one-bit last-grant register picks the side not granted last time. The register resets to "read last", so the first conflict goes to the write.
- **Address mapping:** UP address = AXI address bits [C_ADDR_WIDTH+1:2]. Bits [1:0] are ignored.
- **Write capture:** up_wr_be = wstrb, up_wr_din = wdata. All UP address/data/be outputs are registered at the AXI handshake and held stable until the transaction completes.
- **UP requests:** up_wr_req and up_rd_req are single-cycle pulses, issued in WR_REQ or RD_REQ. The FSM then enters the matching WAIT state with the timeout counter cleared.
- **WAIT state:**
  - The counter increments every cycle.
  - Ack sampled high: capture up_rd_dout (read only), set resp = OKAY, go to RESP.
  - Counter reaches C_TIMEOUT−1 without an ack: resp = SLVERR, rdata = 32'hDEADDEAD, go to RESP.
  - Ack and timeout in the same cycle: the ack wins (OKAY with real data).
- **RESP state:** bvalid or rvalid is held high, with bresp/rresp and rdata stable, until bready or rready. Then return to IDLE. The AXI master may take any number of cycles.
- **Ignored acks:** any ack seen outside the matching WAIT state (late, spurious, or on the other channel) is ignored and has no effect.
- **Reset values:** all readies 0, bvalid 0, rvalid 0, bresp 00, rresp 00, rdata 0, up_wr_req 0, up_rd_req 0, and all UP addr/be/din outputs 0.
- **Reset mid-transaction:** abandon the transaction immediately. No req or valid is produced after reset, and outputs return to their reset values asynchronously.

## Timing
- Let H be the AXI address handshake cycle.
  - Request pulse: cycle H+1, exactly one cycle wide.
  - Ack window: acks are sampled from cycle H+2 onward. An ack in cycle H+1 (same cycle as req) is ignored.
  - Response: ack at cycle A gives bvalid/rvalid at A+1. With a zero-wait responder (ack one cycle after req): req at H+1, ack at H+2, valid at H+3.
  - Timeout: no ack gives valid at H+2+C_TIMEOUT.
- Turnaround: a response accepted in cycle R returns the FSM to IDLE at R+1. The next handshake can occur at R+1 at the earliest.
- Throughput: at most one transaction every 4 cycles with a zero-wait responder and ready always high.

## Test plan
- **Zero-wait write:** AXI write addr 0x0000_0010, data 0xA5A5_1234, wstrb 0xF; responder acks one cycle after req → up_wr_addr = 4, up_wr_be = 0xF, single req pulse, bvalid 3 cycles after handshake with bresp 00.
- **Read with wait states:** read addr 0x0000_0FFC with C_ADDR_WIDTH = 10; responder acks 5 cycles after req with dout 0xCAFE_F00D → up_rd_addr = 0x3FF, rdata 0xCAFE_F00D, rresp 00.
- **Timeout:** read with responder never acking, C_TIMEOUT = 64 → rvalid at H+66, rresp 10, rdata 0xDEAD_DEAD. A late ack injected afterwards changes nothing.
- **Simultaneous write and read:** AW+W and AR presented in the same cycle from reset, twice in a row → order is write, read, write, read, with no overlap of UP requests.
- **Backpressure and channel skew:**
  - bready held low for 10 cycles → bvalid and bresp stay stable and no new handshake is accepted.
  - awvalid without wvalid → awready stays 0.
- **Reset mid-transaction:** assert rst_n low during WR_WAIT → all outputs take reset values immediately. After release, a fresh read completes normally with no stale bvalid.
